// File: rtl/snes_multi_controller_if.sv
// Pad-side and CPU-side signal bundle for snes_multi_controller.
// The controller connects through the slave modport; the host/pad side uses master.
interface snes_multi_controller_if #(
  parameter int NUM_PADS = 2,
  parameter int NUM_BITS = 16
);
  logic                         MODE;
  logic                         START;
  logic [NUM_PADS-1:0]          DATA;
  logic                         LATCH;
  logic                         PULSE;
  logic [NUM_PADS*NUM_BITS-1:0] BUTTONS;
  logic [NUM_PADS*NUM_BITS-1:0] PRESSED;
  logic [NUM_PADS*NUM_BITS-1:0] RELEASED;
  logic                         VALID;
  logic                         BUSY;

  modport master (
    output MODE, START, DATA,
    input  LATCH, PULSE, BUTTONS, PRESSED, RELEASED, VALID, BUSY
  );

  modport slave (
    input  MODE, START, DATA,
    output LATCH, PULSE, BUTTONS, PRESSED, RELEASED, VALID, BUSY
  );
endinterface

// File: rtl/snes_multi_controller.sv
// Multi-pad NES/SNES controller poller: shared LATCH/PULSE, one DATA line per pad,
// held-button state plus one-cycle press/release strobes per frame.
module snes_multi_controller #(
  parameter int NUM_PADS     = 2,
  parameter int NUM_BITS     = 16,
  parameter int LATCH_CYCLES = 600,
  parameter int HALF_CYCLES  = 300,
  parameter int POLL_CYCLES  = 833333
) (
  input logic                   CLOCK,
  input logic                   CLR_N,
  snes_multi_controller_if.slave bus
);

  localparam int PH_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int BIT_W  = $clog2(NUM_BITS) + 1;
  localparam int IDX_W  = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int W      = NUM_PADS * NUM_BITS;

  typedef enum logic [2:0] {
    IDLE,
    LATCH_ST,
    SETTLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t                             state, state_n;
  logic [PH_W-1:0]                    phase, phase_n;
  logic [BIT_W-1:0]                   bit_idx, bit_n;
  logic [POLL_W-1:0]                  poll;
  logic [NUM_PADS-1:0]                sync_meta, sync_data;
  logic [NUM_BITS-1:0][NUM_PADS-1:0]  shadow;
  logic [W-1:0]                       shadow_flat;
  logic [W-1:0]                       buttons_q, pressed_q, released_q;
  logic                               valid_q;
  logic                               sample, done, trigger;
  logic                               latch_last, half_last, bit_last;
  logic [IDX_W-1:0]                   sample_idx;

  assign latch_last = (phase == PH_W'(LATCH_CYCLES - 1));
  assign half_last  = (phase == PH_W'(HALF_CYCLES - 1));
  assign bit_last   = (bit_idx == BIT_W'(NUM_BITS - 1));
  assign sample_idx = bit_idx[IDX_W-1:0];
  assign trigger    = bus.MODE ? (poll == POLL_W'(POLL_CYCLES - 1)) : bus.START;

  assign bus.LATCH    = (state == LATCH_ST);
  assign bus.PULSE    = (state != LOW);
  assign bus.BUSY     = (state != IDLE);
  assign bus.BUTTONS  = buttons_q;
  assign bus.PRESSED  = pressed_q;
  assign bus.RELEASED = released_q;
  assign bus.VALID    = valid_q;

  // Two-flop synchroniser per pad DATA line; idles high (no button pressed).
  always_ff @(posedge CLOCK or negedge CLR_N) begin
    if (!CLR_N) begin
      sync_meta <= '1;
      sync_data <= '1;
    end else begin
      sync_meta <= bus.DATA;
      sync_data <= sync_meta;
    end
  end

  // Poll timer: free-runs and wraps in free-run mode, held at zero otherwise.
  always_ff @(posedge CLOCK or negedge CLR_N) begin
    if (!CLR_N) begin
      poll <= '0;
    end else if (!bus.MODE || poll == POLL_W'(POLL_CYCLES - 1)) begin
      poll <= '0;
    end else begin
      poll <= poll + POLL_W'(1);
    end
  end

  // Frame FSM state, phase counter and bit index registers.
  always_ff @(posedge CLOCK or negedge CLR_N) begin
    if (!CLR_N) begin
      state   <= IDLE;
      phase   <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      bit_idx <= bit_n;
    end
  end

  // Next-state logic; SETTLE and HIGH share the end-of-phase sample step.
  always_comb begin
    state_n = state;
    phase_n = phase + PH_W'(1);
    bit_n   = bit_idx;
    sample  = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        phase_n = '0;
        bit_n   = '0;
        if (trigger) state_n = LATCH_ST;
      end
      LATCH_ST: begin
        if (latch_last) begin
          phase_n = '0;
          state_n = SETTLE;
        end
      end
      SETTLE, HIGH: begin
        if (half_last) begin
          sample  = 1'b1;
          phase_n = '0;
          bit_n   = bit_idx + BIT_W'(1);
          state_n = bit_last ? DONE : LOW;
        end
      end
      LOW: begin
        if (half_last) begin
          phase_n = '0;
          state_n = HIGH;
        end
      end
      DONE: begin
        done    = 1'b1;
        phase_n = '0;
        state_n = IDLE;
      end
      default: begin
        phase_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Shadow register collects one active-high bit per pad at each sample point.
  always_ff @(posedge CLOCK or negedge CLR_N) begin
    if (!CLR_N) begin
      shadow <= '0;
    end else if (sample) begin
      shadow[sample_idx] <= ~sync_data;
    end
  end

  // Reorder shadow (bit-major) into the pad-major output layout.
  always_comb begin
    shadow_flat = '0;
    for (int unsigned p = 0; p < NUM_PADS; p++) begin
      for (int unsigned k = 0; k < NUM_BITS; k++) begin
        shadow_flat[p*NUM_BITS + k] = shadow[k][p];
      end
    end
  end

  // Publish the frame on DONE and generate one-cycle edge strobes.
  always_ff @(posedge CLOCK or negedge CLR_N) begin
    if (!CLR_N) begin
      buttons_q  <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      valid_q    <= 1'b0;
    end else if (done) begin
      buttons_q  <= shadow_flat;
      pressed_q  <= shadow_flat & ~buttons_q;
      released_q <= ~shadow_flat & buttons_q;
      valid_q    <= 1'b1;
    end else begin
      pressed_q  <= '0;
      released_q <= '0;
      valid_q    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_snes_multi_controller.sv
// Self-checking bench for snes_multi_controller: a 2-pad NES instance and a
// 1-pad SNES instance, driven by behavioural pad models.
module tb_snes_multi_controller;

  localparam int NP  = 2;
  localparam int NB  = 8;
  localparam int LC  = 4;
  localparam int HC  = 2;
  localparam int PC  = 100;
  localparam int FL  = LC + HC + (NB - 1) * 2 * HC;
  localparam int NB1 = 16;
  localparam int PC1 = 200;
  localparam int FL1 = LC + HC + (NB1 - 1) * 2 * HC;

  logic CLOCK = 1'b0;
  logic CLR_N = 1'b0;
  always #5 CLOCK = ~CLOCK;

  snes_multi_controller_if #(.NUM_PADS(NP), .NUM_BITS(NB))  bus0 ();
  snes_multi_controller_if #(.NUM_PADS(1),  .NUM_BITS(NB1)) bus1 ();

  snes_multi_controller #(
    .NUM_PADS(NP), .NUM_BITS(NB), .LATCH_CYCLES(LC), .HALF_CYCLES(HC), .POLL_CYCLES(PC)
  ) u_dut0 (.CLOCK(CLOCK), .CLR_N(CLR_N), .bus(bus0));

  snes_multi_controller #(
    .NUM_PADS(1), .NUM_BITS(NB1), .LATCH_CYCLES(LC), .HALF_CYCLES(HC), .POLL_CYCLES(PC1)
  ) u_dut1 (.CLOCK(CLOCK), .CLR_N(CLR_N), .bus(bus1));

  // Pad models: button word latched on LATCH, next bit presented after each PULSE fall.
  logic [7:0]  pad0_val = '0;
  logic [7:0]  pad1_val = '0;
  logic [15:0] padx_val = '0;
  int idx0 = 0;
  int idx1 = 0;

  always @(posedge bus0.LATCH or negedge bus0.PULSE)
    if (bus0.LATCH) idx0 = 0; else idx0 = idx0 + 1;

  always @(posedge bus1.LATCH or negedge bus1.PULSE)
    if (bus1.LATCH) idx1 = 0; else idx1 = idx1 + 1;

  function automatic logic pad_line(input logic [15:0] v, input int i);
    logic [15:0] s;
    s = v >> i;
    return ~s[0];
  endfunction

  assign bus0.DATA = {pad_line({8'h00, pad1_val}, idx0), pad_line({8'h00, pad0_val}, idx0)};
  assign bus1.DATA = pad_line(padx_val, idx1);

  int checks = 0;
  int errors = 0;
  logic [15:0] ref_buttons  = '0;
  logic [15:0] ref_buttons1 = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK);
  endtask

  // PULSE is low during the LOW half of each of the nb-1 shift periods after SETTLE.
  function automatic bit pulse_low(input int o, input int nb);
    int s;
    if (o < 1 + LC + HC) return 1'b0;
    s = o - (1 + LC + HC);
    return (s / (2 * HC) < nb - 1) && (s % (2 * HC) < HC);
  endfunction

  task automatic frame0(input logic [7:0] p0, input logic [7:0] p1, input bit spam);
    logic [15:0] nw;
    int falls;
    logic prev_pulse;
    nw = {p1, p0};
    pad0_val = p0;
    pad1_val = p1;
    falls = 0;
    prev_pulse = 1'b1;
    bus0.START = 1'b1;
    for (int o = 1; o <= FL + 3; o++) begin
      tick();
      if (prev_pulse && !bus0.PULSE) falls++;
      prev_pulse = bus0.PULSE;
      check("latch", 64'(bus0.LATCH), 64'(o <= LC));
      check("pulse", 64'(bus0.PULSE), 64'(!pulse_low(o, NB)));
      check("busy",  64'(bus0.BUSY),  64'(o <= FL + 1));
      check("valid", 64'(bus0.VALID), 64'(o == FL + 2));
      if (o == FL + 2) begin
        check("buttons",  64'(bus0.BUTTONS),  64'(nw));
        check("pressed",  64'(bus0.PRESSED),  64'(nw & ~ref_buttons));
        check("released", 64'(bus0.RELEASED), 64'(ref_buttons & ~nw));
      end
      if (o == FL + 3) begin
        check("buttons_hold", 64'(bus0.BUTTONS),  64'(nw));
        check("pressed_clr",  64'(bus0.PRESSED),  64'd0);
        check("released_clr", 64'(bus0.RELEASED), 64'd0);
      end
      bus0.START = (spam && o <= FL) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    check("pulse_falls", 64'(falls), 64'(NB - 1));
    ref_buttons = nw;
  endtask

  task automatic frame1(input logic [15:0] v);
    int falls;
    logic prev_pulse;
    padx_val = v;
    falls = 0;
    prev_pulse = 1'b1;
    bus1.START = 1'b1;
    for (int o = 1; o <= FL1 + 3; o++) begin
      tick();
      bus1.START = 1'b0;
      if (prev_pulse && !bus1.PULSE) falls++;
      prev_pulse = bus1.PULSE;
      check("s_busy",  64'(bus1.BUSY),  64'(o <= FL1 + 1));
      check("s_valid", 64'(bus1.VALID), 64'(o == FL1 + 2));
      if (o == FL1 + 2) begin
        check("s_buttons",  64'(bus1.BUTTONS),  64'(v));
        check("s_pressed",  64'(bus1.PRESSED),  64'(v & ~ref_buttons1));
        check("s_released", 64'(bus1.RELEASED), 64'(ref_buttons1 & ~v));
      end
    end
    check("s_pulse_falls", 64'(falls), 64'(NB1 - 1));
    ref_buttons1 = v;
  endtask

  task automatic free_run();
    logic [15:0] nw;
    int rises, valids, last_rise, first_rise, late_latch;
    logic prev_latch;
    pad0_val = 8'($urandom);
    pad1_val = 8'($urandom);
    nw = {pad1_val, pad0_val};
    rises = 0; valids = 0; last_rise = 0; first_rise = 0; late_latch = 0;
    prev_latch = 1'b0;
    bus0.MODE = 1'b1;
    for (int c = 1; c <= 350; c++) begin
      tick();
      if (bus0.LATCH && !prev_latch) begin
        if (rises == 0) first_rise = c;
        else check("poll_gap", 64'(c - last_rise), 64'(PC));
        rises++;
        last_rise = c;
      end
      prev_latch = bus0.LATCH;
      if (bus0.VALID) begin
        valids++;
        check("fr_buttons",  64'(bus0.BUTTONS),  64'(nw));
        check("fr_pressed",  64'(bus0.PRESSED),  64'(nw & ~ref_buttons));
        check("fr_released", 64'(bus0.RELEASED), 64'(ref_buttons & ~nw));
        ref_buttons = nw;
      end
      bus0.START = 1'($urandom_range(0, 1));
    end
    bus0.MODE = 1'b0;
    bus0.START = 1'b0;
    check("poll_rises",  64'(rises),  64'd3);
    check("poll_valids", 64'(valids), 64'd3);
    check("first_rise_window", 64'(first_rise > 0 && first_rise <= PC), 64'd1);
    for (int c = 0; c < 120; c++) begin
      tick();
      if (bus0.LATCH || bus0.VALID) late_latch++;
    end
    check("no_frame_after_mode0", 64'(late_latch), 64'd0);
  endtask

  task automatic reset_mid_frame();
    int stray;
    pad0_val = 8'($urandom);
    pad1_val = 8'($urandom);
    bus0.START = 1'b1;
    for (int o = 1; o <= 1 + LC + HC + 4 * 2 * HC; o++) begin
      tick();
      bus0.START = 1'b0;
    end
    check("rst_in_low5", 64'(bus0.PULSE), 64'd0);
    CLR_N = 1'b0;
    #1;
    check("rst_latch",   64'(bus0.LATCH),   64'd0);
    check("rst_pulse",   64'(bus0.PULSE),   64'd1);
    check("rst_busy",    64'(bus0.BUSY),    64'd0);
    check("rst_buttons", 64'(bus0.BUTTONS), 64'd0);
    check("rst_valid",   64'(bus0.VALID),   64'd0);
    repeat (3) tick();
    CLR_N = 1'b1;
    ref_buttons  = '0;
    ref_buttons1 = '0;
    stray = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (bus0.VALID || bus0.BUSY) stray++;
    end
    check("rst_no_valid", 64'(stray), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idle_bad;
    bus0.MODE = 1'b0; bus0.START = 1'b0;
    bus1.MODE = 1'b0; bus1.START = 1'b0;
    CLR_N = 1'b0;
    repeat (3) tick();
    check("reset_latch",   64'(bus0.LATCH),    64'd0);
    check("reset_pulse",   64'(bus0.PULSE),    64'd1);
    check("reset_busy",    64'(bus0.BUSY),     64'd0);
    check("reset_valid",   64'(bus0.VALID),    64'd0);
    check("reset_outputs", 64'({bus0.BUTTONS, bus0.PRESSED, bus0.RELEASED}), 64'd0);
    check("reset_s_outs",  64'({bus1.BUTTONS, bus1.LATCH, bus1.BUSY}), 64'd0);
    CLR_N = 1'b1;

    idle_bad = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (bus0.LATCH || !bus0.PULSE || bus0.BUSY || bus0.VALID ||
          bus0.BUTTONS != '0 || bus0.PRESSED != '0 || bus0.RELEASED != '0)
        idle_bad++;
    end
    check("idle_200", 64'(idle_bad), 64'd0);

    frame0(8'h5A, 8'hC3, 1'b0);
    frame0(8'h0F, 8'hC3, 1'b1);
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 5)) begin
        tick();
        check("gap_busy", 64'(bus0.BUSY), 64'd0);
      end
      frame0(8'($urandom), 8'($urandom), 1'b1);
    end

    free_run();
    reset_mid_frame();

    frame1(16'h0000);
    frame1(16'($urandom));
    frame1(16'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
